// File: rtl/aes_round_ctrl_3share.sv
// Round sequencer for a 3-share AES-128 encryption datapath.
// Holds the three state shares, drives them into an external S-box layer of
// fixed latency, and applies ShiftRows/MixColumns/AddRoundKey share-wise on
// the way back. Shares are never combined inside this block.
//
// state | meaning
// IDLE  | waiting for start; ciphertext shares held on st1..3
// LOAD  | alias of the IDLE accept path (same load), not entered on its own
// SBOX  | S-box layer busy; wait counter runs 0..SBOX_LAT-1, shares frozen
// LIN   | linear layer + round key applied per share, round advance
module aes_round_ctrl_3share #(
  parameter int SBOX_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] pt1,
  input  logic [127:0] pt2,
  input  logic [127:0] pt3,
  input  logic [127:0] rk1,
  input  logic [127:0] rk2,
  input  logic [127:0] rk3,
  input  logic [127:0] sb1,
  input  logic [127:0] sb2,
  input  logic [127:0] sb3,
  output logic [127:0] st1,
  output logic [127:0] st2,
  output logic [127:0] st3,
  output logic         guards_sel,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SBOX_LAT - 1);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {IDLE, LOAD, SBOX, LIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [3:0]    round_q, round_d;
  logic [127:0]  st1_q, st2_q, st3_q;
  logic [127:0]  st1_d, st2_d, st3_d;
  logic          done_q, done_d;
  logic          load;
  logic          last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // byte j sits at row j%4, column j/4; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[8*(rr+4*c) +: 8] = s[8*(rr+4*((c+rr)%4)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // linear part of a round is share-wise linear, so each share goes alone
  function automatic logic [127:0] round_lin(input logic [127:0] sb,
                                             input logic [127:0] rk,
                                             input logic         final_rnd);
    logic [127:0] t;
    t = shift_rows(sb);
    if (!final_rnd) t = mix_columns(t);
    return t ^ rk;
  endfunction

  assign load       = ((state_q == IDLE) && start) || (state_q == LOAD);
  assign last_round = (round_q == LAST_ROUND);

  // next-state, counters and share updates
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    round_d = round_q;
    st1_d   = st1_q;
    st2_d   = st2_q;
    st3_d   = st3_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (load) begin
          st1_d   = pt1 ^ rk1;
          st2_d   = pt2 ^ rk2;
          st3_d   = pt3 ^ rk3;
          round_d = 4'd1;
          wait_d  = '0;
          state_d = SBOX;
        end
      end
      SBOX: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = LIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LIN: begin
        st1_d  = round_lin(sb1, rk1, last_round);
        st2_d  = round_lin(sb2, rk2, last_round);
        st3_d  = round_lin(sb3, rk3, last_round);
        wait_d = '0;
        if (last_round) begin
          // back to 0 so the next accept sees the whitening key
          round_d = 4'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = SBOX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      round_q <= '0;
      st1_q   <= '0;
      st2_q   <= '0;
      st3_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      round_q <= round_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      st3_q   <= st3_d;
      done_q  <= done_d;
    end
  end

  assign st1        = st1_q;
  assign st2        = st2_q;
  assign st3        = st3_q;
  assign round_idx  = round_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  // fresh guards only for the very first S-box pass of an encryption
  assign guards_sel = (state_q == SBOX) && (wait_q == '0) && (round_q == 4'd1);

endmodule

// File: tb/tb_aes_round_ctrl_3share.sv
// Bench for aes_round_ctrl_3share: two instances (S-box latency 4 and 1)
// share start/rst/plaintext; each gets its own key-share feed, a 3-share
// S-box reference pipeline, and a scoreboard of expected ciphertext/cycle.
module tb_aes_round_ctrl_3share;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] pt1, pt2, pt3;
  logic [127:0] exp_ct;
  logic [7:0]   sbox_t [256];
  logic [127:0] rkf [11];
  logic [127:0] km1 [11];
  logic [127:0] km2 [11];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  // free-running clock
  always #5 clk = ~clk;

  // cycle counter, read at negedge by the monitors
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [127:0] a, input logic [127:0] b);
    checks++;
    assert (a !== b) else begin
      errors++;
      $error("FAIL %s: observed %h expected a different value", tag, a);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox_t[s[8*j +: 8]];
    return r;
  endfunction

  // FIPS hex strings put byte 0 first (MSB); the design has byte 0 at LSB
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = x[8*(15-j) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, bi;
    for (int i = 0; i < 256; i++) begin
      bi  = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(bi, 8'(j)) == 8'h01) inv = 8'(j);
      sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] t0, t1, t2, t3, tmp, rc;
    for (int j = 0; j < 16; j++) w[j] = key[8*j +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t0 = w[4*(i-1)]; t1 = w[4*(i-1)+1]; t2 = w[4*(i-1)+2]; t3 = w[4*(i-1)+3];
      if (i % 4 == 0) begin
        tmp = t0;
        t0  = sbox_t[t1] ^ rc;
        t1  = sbox_t[t2];
        t2  = sbox_t[t3];
        t3  = sbox_t[tmp];
        rc  = xt(rc);
      end
      w[4*i]   = w[4*(i-4)]   ^ t0;
      w[4*i+1] = w[4*(i-4)+1] ^ t1;
      w[4*i+2] = w[4*(i-4)+2] ^ t2;
      w[4*i+3] = w[4*(i-4)+3] ^ t3;
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) rkf[r][8*j +: 8] = w[16*r+j];
  endtask

  // fresh key and plaintext share randomness for a vector
  task automatic load_vec(input logic [127:0] key_f, input logic [127:0] pt_f,
                          input logic [127:0] ct_f);
    logic [127:0] a, b;
    expand_key(bswap(key_f));
    for (int r = 0; r < 11; r++) begin
      km1[r] = rnd128();
      km2[r] = rnd128();
    end
    a = rnd128();
    b = rnd128();
    pt1 = bswap(pt_f) ^ a ^ b;
    pt2 = a;
    pt3 = b;
    exp_ct = bswap(ct_f);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int LAT = (g == 0) ? 4 : 1;
    localparam int LATENCY = 1 + 10 * (LAT + 1);

    logic [127:0] rk1, rk2, rk3, sb1, sb2, sb3, st1, st2, st3;
    logic [127:0] p1 [LAT];
    logic [127:0] p2 [LAT];
    logic [127:0] p3 [LAT];
    logic [127:0] m_a, m_b;
    logic         guards_sel, busy, done;
    logic [3:0]   round_idx;
    int           ri;
    exp_t         q[$];
    exp_t         e;
    int           gcnt = 0;
    int           ndone = 0;
    int           npend = 0;

    aes_round_ctrl_3share #(.SBOX_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .rk1(rk1), .rk2(rk2), .rk3(rk3),
      .sb1(sb1), .sb2(sb2), .sb3(sb3),
      .st1(st1), .st2(st2), .st3(st3),
      .guards_sel(guards_sel), .round_idx(round_idx),
      .busy(busy), .done(done)
    );

    // round-key shares for whatever round the DUT reports
    always_comb begin
      ri  = (round_idx > 4'd10) ? 0 : int'(round_idx);
      rk2 = km1[ri];
      rk3 = km2[ri];
      rk1 = rkf[ri] ^ km1[ri] ^ km2[ri];
    end

    // reference 3-share S-box layer: LAT register stages, freshly remasked
    always @(posedge clk) begin
      m_a   <= rnd128();
      m_b   <= rnd128();
      p1[0] <= m_a;
      p2[0] <= m_b;
      p3[0] <= sub_bytes(st1 ^ st2 ^ st3) ^ m_a ^ m_b;
      for (int s = 1; s < LAT; s++) begin
        p1[s] <= p1[s-1];
        p2[s] <= p2[s-1];
        p3[s] <= p3[s-1];
      end
    end
    assign sb1 = p1[LAT-1];
    assign sb2 = p2[LAT-1];
    assign sb3 = p3[LAT-1];

    // scoreboard: check done/guards, push on accepted start
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        gcnt = 0;
      end else begin
        if (done) begin
          chk($sformatf("done_expected_%0d", g), {127'b0, q.size() != 0}, 128'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("done_cycle_%0d", g), 128'(cyc), 128'(e.due));
            chk($sformatf("ciphertext_%0d", g), st1 ^ st2 ^ st3, e.ct);
            chk($sformatf("guards_count_%0d", g), 128'(gcnt), 128'd1);
            ndone++;
          end
        end else if (q.size() != 0 && cyc >= q[0].due) begin
          chk($sformatf("done_timeout_%0d", g), 128'd0, 128'd1);
          void'(q.pop_front());
        end
        if (guards_sel) begin
          gcnt++;
          chk($sformatf("guards_cycle_%0d", g), 128'(cyc),
              (q.size() != 0) ? 128'(q[0].due - (LATENCY - 1)) : 128'hffff);
        end
        if (start && !busy) begin
          q.push_back('{exp_ct, cyc + LATENCY});
          gcnt = 0;
        end
      end
      npend = q.size();
    end
  end

  logic [127:0] run_a_st1;
  int           nd0, nd1;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pt1 = '0; pt2 = '0; pt3 = '0;
    exp_ct = '0;
    build_sbox();
    load_vec(128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    step(3);
    chk("rst_busy", 128'(gd[0].busy), 128'd0);
    chk("rst_round", 128'(gd[0].round_idx), 128'd0);
    chk("rst_st", gd[0].st1 | gd[0].st2 | gd[0].st3, 128'd0);
    chk("rst_done_guards", {126'b0, gd[0].done, gd[0].guards_sel}, 128'd0);
    rst = 1'b0;
    step(4);
    chk("idle_hold_st", gd[0].st1 | gd[0].st2 | gd[0].st3, 128'd0);
    chk("idle_busy", 128'(gd[1].busy), 128'd0);

    // C.1 vector
    start = 1'b1; step(1); start = 1'b0;
    chk("busy_after_accept", 128'(gd[0].busy), 128'd1);
    step(60);
    chk("ct_hold_0", gd[0].st1 ^ gd[0].st2 ^ gd[0].st3, exp_ct);
    chk("ct_hold_1", gd[1].st1 ^ gd[1].st2 ^ gd[1].st3, exp_ct);
    run_a_st1 = gd[0].st1;

    // same vector, fresh randomness
    load_vec(128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    start = 1'b1; step(1); start = 1'b0;
    step(60);
    chk("ct_rerun", gd[0].st1 ^ gd[0].st2 ^ gd[0].st3, exp_ct);
    chk_ne("share_differs", gd[0].st1, run_a_st1);

    // second known-answer vector
    load_vec(128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734,
             128'h3925841d02dc09fbdc118597196a0b32);
    start = 1'b1; step(1); start = 1'b0;
    step(60);
    chk("ct_vec_b", gd[0].st1 ^ gd[0].st2 ^ gd[0].st3, exp_ct);

    // start pulses at +5 and +30 are ignored by the busy instance
    nd0 = gd[0].ndone;
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    start = 1'b1; step(1); start = 1'b0;
    step(24);
    start = 1'b1; step(1); start = 1'b0;
    step(40);
    chk("one_done_ignored_starts", 128'(gd[0].ndone - nd0), 128'd1);

    // reset at +20 abandons the run
    nd0 = gd[0].ndone;
    nd1 = gd[1].ndone;
    start = 1'b1; step(1); start = 1'b0;
    step(19);
    chk("mid_round_0", 128'(gd[0].round_idx), 128'd4);
    chk("mid_round_1", 128'(gd[1].round_idx), 128'd10);
    rst = 1'b1; step(1);
    chk("abort_busy", 128'(gd[0].busy), 128'd0);
    chk("abort_round", 128'(gd[0].round_idx), 128'd0);
    chk("abort_st", gd[0].st1 | gd[0].st2 | gd[0].st3, 128'd0);
    rst = 1'b0;
    step(60);
    chk("no_done_after_abort_0", 128'(gd[0].ndone - nd0), 128'd0);
    chk("no_done_after_abort_1", 128'(gd[1].ndone - nd1), 128'd0);

    // first start after reset, then back-to-back with start held
    load_vec(128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    nd0 = gd[0].ndone;
    start = 1'b1;
    step(153);
    start = 1'b0;
    step(60);
    chk("back_to_back_count", 128'(gd[0].ndone - nd0), 128'd3);
    chk("pending_0", 128'(gd[0].npend), 128'd0);
    chk("pending_1", 128'(gd[1].npend), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
